round_robin_fifo_distributor: RTL and testbench
===============================================

ROUND_ROBIN_FIFO_DISTRIBUTOR -- requirements
Module: round_robin_fifo_distributor

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entries per output FIFO (power of two).
REQ-002 SHALL have parameter W, default 8, data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wen  input  1  producer write strobe, one word per cycle.
REQ-006 SHALL have port din  input  W  producer write data.
REQ-007 SHALL have port in_error  output  1  one-cycle pulse: last write rejected (target FIFO full).
REQ-008 SHALL have port ptr  output  2  current round-robin target (0=a, 1=b, 2=c, 3=d).
REQ-009 SHALL have port ren  input  4  per-consumer read strobe; bit i reads FIFO i.
REQ-010 SHALL have ports a, b, c, d  output  W each  registered read data of FIFO 0..3.
REQ-011 SHALL have port valid  output  4  bit i one-cycle pulse: registered data on FIFO i output is new.
REQ-012 SHALL have port rd_error  output  4  bit i one-cycle pulse: read of empty FIFO i.
REQ-013 SHALL have ports full, empty  output  4 each  combinational status per FIFO, from registered counts.

Function
REQ-014 SHALL contain four independent circular FIFOs, each with read pointer, write pointer and count of width log2(DEPTH)+1.
REQ-015 SHALL route an accepted write (wen=1, FIFO[ptr] not full or being read same cycle) into FIFO[ptr] at the edge, then advance ptr by 1 modulo 4 (3 wraps to 0).
REQ-016 SHALL reject a write when FIFO[ptr] is full and ren[ptr]=0: no storage, ptr unchanged, in_error=1 for the next cycle only.
REQ-017 SHALL leave ptr unchanged and in_error=0 when wen=0.
REQ-018 SHALL on ren[i]=1 with FIFO i non-empty: register the head word onto output i, advance its read pointer, decrement its count, set valid[i]=1 for the next cycle.
REQ-019 SHALL on ren[i]=1 with FIFO i empty: hold output i, valid[i]=0, rd_error[i]=1 for the next cycle; no pointer change.
REQ-020 SHALL hold each data output at its last value when not reading; valid[i] and rd_error[i] return to 0 when ren[i]=0.
REQ-021 SHALL on simultaneous write and read of the same non-empty FIFO perform both, count unchanged; a full FIFO being read accepts the write.
REQ-022 SHALL on simultaneous write and read of the same empty FIFO perform the write, report rd_error for the read; no same-cycle bypass.
REQ-023 SHALL allow reads of all four FIFOs and the write in the same cycle, each independent except as in REQ-021/022.
REQ-024 SHALL give minimum write-to-read latency: word written at edge N is readable by ren asserted in the cycle after edge N, appearing on output after edge N+1.
REQ-025 SHALL preserve per-FIFO order; overall, FIFO i receives input words i, i+4, i+8, ... when no write is rejected.
REQ-026 SHALL wrap read/write pointers from DEPTH-1 to 0 without affecting count.

Reset
REQ-027 SHALL on rst_n=0, asynchronously: ptr=0, all pointers and counts=0, a..d=0, valid=0, rd_error=0, in_error=0, empty=4'b1111, full=0.
REQ-028 SHALL discard all stored data on reset asserted mid-operation; the first write after release goes to FIFO a.
REQ-029 SHALL ignore wen and ren while rst_n=0.

Verification
REQ-030 SHALL cover: reset, write 0x10..0x17 (8 cycles) -> ptr sequence 0,1,2,3,0,1,2,3,0; each FIFO count 2; empty=0000.
REQ-031 SHALL cover: after REQ-030, ren=4'b1111 two cycles -> a,b,c,d = 0x10,0x11,0x12,0x13 then 0x14,0x15,0x16,0x17; valid=1111 both cycles; then empty=1111.
REQ-032 SHALL cover: write 32 words, no reads -> full=1111; 33rd write -> in_error pulse, ptr stays 0, data lost; read FIFO a 8 times yields words 0,4,...,28.
REQ-033 SHALL cover: ren[2]=1 on empty FIFO c -> rd_error=4'b0100 one cycle, valid[2]=0, c unchanged.
REQ-034 SHALL cover: FIFO a full, ptr=0, wen=1 din=0xAA with ren[0]=1 -> write accepted, a=oldest word, count stays 8, ptr=1, in_error=0.
REQ-035 SHALL cover: rst_n pulsed low mid-stream with 5 words stored -> all outputs at REQ-027 values immediately; next write din=0x55 lands in FIFO a, read returns 0x55.

Source files
------------

// File: rtl/round_robin_fifo_distributor.sv
// round_robin_fifo_distributor
//   Distributes a single producer stream across four independent circular
//   FIFOs in strict round-robin order (a, b, c, d, a, ...). Each FIFO has its
//   own consumer with a private read strobe and a registered data output.
//
// Ports
//   clk, rst_n      single clock, asynchronous active-low reset
//   wen, din        producer write strobe and data (one word per cycle)
//   in_error        one-cycle pulse: previous write rejected, target FIFO full
//   ptr             current round-robin target FIFO (0=a .. 3=d)
//   ren[3:0]        per-consumer read strobe, bit i reads FIFO i
//   a, b, c, d      registered read data of FIFO 0..3 (held between reads)
//   valid[3:0]      one-cycle pulse: output i carries a freshly read word
//   rd_error[3:0]   one-cycle pulse: read of an empty FIFO i
//   full, empty     per-FIFO status decoded from the registered counts
module round_robin_fifo_distributor #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wen,
  input  logic [W-1:0] din,
  output logic         in_error,
  output logic [1:0]   ptr,
  input  logic [3:0]   ren,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic [3:0]   valid,
  output logic [3:0]   rd_error,
  output logic [3:0]   full,
  output logic [3:0]   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem    [4][DEPTH];
  logic [AW-1:0] rd_ptr [4];
  logic [AW-1:0] wr_ptr [4];
  logic [CW-1:0] cnt    [4];
  logic [W-1:0]  dout   [4];

  logic       wr_acc;
  logic [3:0] wr_sel;
  logic [3:0] rd_ok;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      full[i]  = (cnt[i] == FULL_CNT);
      empty[i] = (cnt[i] == '0);
    end
  end

  // A full target still accepts the write when its consumer reads in the
  // same cycle: the read frees the slot the write fills.
  always_comb begin
    wr_acc = wen && (!full[ptr] || ren[ptr]);
    wr_sel = '0;
    if (wr_acc) wr_sel[ptr] = 1'b1;
    // Reads see only the registered count, so a word written this cycle is
    // never bypassed to a same-cycle read of an empty FIFO.
    rd_ok  = ren & ~empty;
  end

  // Storage carries no reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (rst_n && wr_sel[i]) mem[i][wr_ptr[i]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      in_error <= 1'b0;
      valid    <= '0;
      rd_error <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i]    <= '0;
        dout[i]   <= '0;
      end
    end else begin
      in_error <= wen && !wr_acc;
      if (wr_acc) ptr <= ptr + 2'd1;
      valid    <= rd_ok;
      rd_error <= ren & empty;
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_sel[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (rd_ok[i]) begin
          dout[i]   <= mem[i][rd_ptr[i]];
          rd_ptr[i] <= rd_ptr[i] + AW'(1);
        end
        case ({wr_sel[i], rd_ok[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  assign a = dout[0];
  assign b = dout[1];
  assign c = dout[2];
  assign d = dout[3];

endmodule

// File: tb/tb_round_robin_fifo_distributor.sv
// tb_round_robin_fifo_distributor
//   Directed stimulus against a queue-based reference model. The model is
//   updated on every rising edge (and on reset assertion); a single compare
//   process checks every DUT output against it on each falling edge. Literal
//   expectations in the stimulus pin the model to hand-computed values.
module tb_round_robin_fifo_distributor;

  localparam int DEPTH = 8;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         wen = 1'b0;
  logic [W-1:0] din = '0;
  logic [3:0]   ren = '0;
  logic         in_error;
  logic [1:0]   ptr;
  logic [W-1:0] a, b, c, d;
  logic [3:0]   valid, rd_error, full, empty;

  round_robin_fifo_distributor #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen), .din(din),
    .in_error(in_error), .ptr(ptr), .ren(ren),
    .a(a), .b(b), .c(c), .d(d),
    .valid(valid), .rd_error(rd_error), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one unbounded queue per consumer.
  logic [W-1:0] mq [4][$];
  int           m_ptr = 0;
  logic [W-1:0] m_out [4];
  logic [3:0]   m_valid = '0;
  logic [3:0]   m_rderr = '0;
  logic         m_inerr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mq[i].delete();
        m_out[i] = '0;
      end
      m_ptr = 0; m_valid = '0; m_rderr = '0; m_inerr = 1'b0;
    end else begin
      bit acc;
      acc = wen && ((mq[m_ptr].size() < DEPTH) || ren[m_ptr]);
      for (int i = 0; i < 4; i++) begin
        m_valid[i] = 1'b0;
        m_rderr[i] = 1'b0;
        if (ren[i]) begin
          if (mq[i].size() > 0) begin
            m_out[i]   = mq[i].pop_front();
            m_valid[i] = 1'b1;
          end else begin
            m_rderr[i] = 1'b1;
          end
        end
      end
      if (acc) begin
        mq[m_ptr].push_back(din);
        m_ptr = (m_ptr + 1) % 4;
      end
      m_inerr = wen && !acc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] e_full, e_empty;
      for (int i = 0; i < 4; i++) begin
        e_full[i]  = (mq[i].size() == DEPTH);
        e_empty[i] = (mq[i].size() == 0);
      end
      check("ptr",      32'(ptr),      32'(m_ptr));
      check("in_error", 32'(in_error), 32'(m_inerr));
      check("valid",    32'(valid),    32'(m_valid));
      check("rd_error", 32'(rd_error), 32'(m_rderr));
      check("full",     32'(full),     32'(e_full));
      check("empty",    32'(empty),    32'(e_empty));
      check("a", 32'(a), 32'(m_out[0]));
      check("b", 32'(b), 32'(m_out[1]));
      check("c", 32'(c), 32'(m_out[2]));
      check("d", 32'(d), 32'(m_out[3]));
    end
  end

  // Drive one cycle of inputs at the falling edge; return 1 ns after the
  // following rising edge so registered outputs are settled.
  task automatic step(input logic w, input logic [W-1:0] dv, input logic [3:0] r);
    @(negedge clk);
    wen = w; din = dv; ren = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    wen = 1'b0; ren = '0;
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check("rst ptr",   32'(ptr),   32'h0);
    check("rst empty", 32'(empty), 32'hF);
    check("rst full",  32'(full),  32'h0);
    check("rst a",     32'(a),     32'h0);

    // Eight writes: ptr walks 1,2,3,0,... after each edge, two words per FIFO.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 8'(8'h10 + k), 4'b0000);
      check("rr ptr", 32'(ptr), 32'((k + 1) % 4));
    end
    step(1'b0, '0, 4'b0000);
    check("after 8 empty", 32'(empty), 32'h0);

    // Read all four FIFOs twice in parallel.
    step(1'b0, '0, 4'b1111);
    check("rd1 abcd", {a, b, c, d}, 32'h10111213);
    check("rd1 valid", 32'(valid), 32'hF);
    step(1'b0, '0, 4'b1111);
    check("rd2 abcd", {a, b, c, d}, 32'h14151617);
    check("rd2 valid", 32'(valid), 32'hF);
    step(1'b0, '0, 4'b0000);
    check("drained empty", 32'(empty), 32'hF);
    check("idle valid", 32'(valid), 32'h0);

    // Read of empty FIFO c.
    step(1'b0, '0, 4'b0100);
    check("rderr c", 32'(rd_error), 32'h4);
    check("rderr valid", 32'(valid), 32'h0);
    check("rderr c held", 32'(c), 32'h16);
    step(1'b0, '0, 4'b0000);
    check("rderr clears", 32'(rd_error), 32'h0);

    // Fill all FIFOs, then one rejected write.
    for (int k = 0; k < 32; k++) step(1'b1, 8'(k), 4'b0000);
    check("all full", 32'(full), 32'hF);
    step(1'b1, 8'h20, 4'b0000);
    check("ovf in_error", 32'(in_error), 32'h1);
    check("ovf ptr", 32'(ptr), 32'h0);
    step(1'b0, '0, 4'b0000);
    check("ovf pulse ends", 32'(in_error), 32'h0);

    // Write into full FIFO a while it is read.
    step(1'b1, 8'hAA, 4'b0001);
    check("wr+rd full a", 32'(a), 32'h0);
    check("wr+rd full ptr", 32'(ptr), 32'h1);
    check("wr+rd full in_error", 32'(in_error), 32'h0);
    check("wr+rd full still full", 32'(full[0]), 32'h1);
    for (int k = 1; k < 8; k++) begin
      step(1'b0, '0, 4'b0001);
      check("a order", 32'(a), 32'(4 * k));
    end
    step(1'b0, '0, 4'b0001);
    check("a last AA", 32'(a), 32'hAA);

    // Fresh start, five words stored, then asynchronous reset mid-cycle.
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h30 + k), 4'b0000);
    step(1'b0, '0, 4'b0001);
    check("pre-rst a", 32'(a), 32'h30);
    #2 rst_n = 1'b0;
    #1;
    check("async ptr",   32'(ptr),   32'h0);
    check("async empty", 32'(empty), 32'hF);
    check("async a",     32'(a),     32'h0);
    check("async valid", 32'(valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write and read of empty FIFO a in the same cycle: no bypass.
    step(1'b1, 8'h55, 4'b0001);
    check("no bypass rd_error", 32'(rd_error), 32'h1);
    check("no bypass a held", 32'(a), 32'h0);
    step(1'b0, '0, 4'b0001);
    check("post-rst a", 32'(a), 32'h55);
    check("post-rst valid", 32'(valid), 32'h1);
    step(1'b0, '0, 4'b0000);

    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
